// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encodings.
// The unused code 2'd3 is treated as an illegal state and recovers to IDLE.
package seq_shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/seq_shift_add_multiplier_rca.sv
// One-bit full-adder cell and the WIDTH-bit ripple-carry adder built from a chain of them.
// The adder performs the accumulate step of the shift-add multiplier.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = Cin;
  assign Cout     = carry[WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      full_adder u_fa (
        .a    (X[gi]),
        .b    (Y[gi]),
        .cin  (carry[gi]),
        .s    (Sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-add multiplier, one partial product per clock.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: zero operands bypass the iteration (one-step RUN).
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Product
);

  import seq_shift_add_multiplier_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_e      state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] mplr_q;
  logic [CNT_W-1:0] count_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             zero_pair;

  assign addend = mplr_q[0] ? mcand_q : '0;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
    .X    (acc_hi_q),
    .Y    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (carry)
  );

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_pair = (A == '0) || (B == '0);
`else
  assign zero_pair = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      mplr_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= A;
            acc_hi_q   <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
            // A zero pair runs a single all-zero step so out_valid follows one edge later.
            if (zero_pair) begin
              mplr_q  <= '0;
              count_q <= CNT_W'(1);
            end else begin
              mplr_q  <= B;
              count_q <= CNT_W'(WIDTH);
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_hi_q <= {carry, sum[WIDTH-1:1]};
          mplr_q   <= {sum[0], mplr_q[WIDTH-1:1]};
          count_q  <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          // Product is left untouched on acceptance; only the handshake clears.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Product   = {acc_hi_q, mplr_q};

endmodule
